// File: rtl/quadrature_gen.sv
`default_nettype none
// ============================================================================
// Module   : quadrature_gen
// Brief    : Quadrature A/B generator; steps position toward target, one full
//            Gray-code cycle per count, with a programmable phase length.
// Revision : 1.0
// ============================================================================
module quadrature_gen #(
  parameter int WIDTH = 32,
  parameter int TW    = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] target,
  input  logic [TW-1:0]    quarter_cycles,
  input  logic             preset,
  input  logic [WIDTH-1:0] preset_value,
  output logic             A,
  output logic             B,
  output logic [WIDTH-1:0] position,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PH1  = 3'd1,
    S_PH2  = 3'd2,
    S_PH3  = 3'd3,
    S_PH4  = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] C_POS_ONE = WIDTH'(1);
  localparam logic [TW-1:0]    C_TMR_ONE = TW'(1);

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [TW-1:0]    qlen_q, qlen_d;
  logic             dir_q, dir_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] pos_q, pos_d;

  logic             w_phase_end;
  logic [WIDTH-1:0] w_pos_step;

  // {A,B} for a given phase; down direction swaps channels, keeping 00 last.
  function automatic logic [1:0] phase_ab(input state_t s, input logic up);
    logic [1:0] ab;
    ab = 2'b00;
    case (s)
      S_PH1:   ab = up ? 2'b10 : 2'b01;
      S_PH2:   ab = 2'b11;
      S_PH3:   ab = up ? 2'b01 : 2'b10;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

  assign w_phase_end = (timer_q == qlen_q);
  assign w_pos_step  = dir_q ? (pos_q + C_POS_ONE) : (pos_q - C_POS_ONE);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      qlen_q  <= C_TMR_ONE;
      dir_q   <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      qlen_q  <= qlen_d;
      dir_q   <= dir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    qlen_d  = qlen_q;
    dir_d   = dir_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pos_d   = pos_q;

    case (state_q)
      S_IDLE: begin
        if (preset) begin
          pos_d = preset_value;
        end else if (enable && (target != pos_q)) begin
          dir_d         = (target > pos_q);
          qlen_d        = (quarter_cycles == '0) ? C_TMR_ONE : quarter_cycles;
          timer_d       = C_TMR_ONE;
          state_d       = S_PH1;
          busy_d        = 1'b1;
          {a_d, b_d}    = phase_ab(S_PH1, target > pos_q);
        end
      end
      S_PH1, S_PH2, S_PH3: begin
        if (w_phase_end) begin
          timer_d    = C_TMR_ONE;
          state_d    = state_t'(state_q + 3'd1);
          {a_d, b_d} = phase_ab(state_t'(state_q + 3'd1), dir_q);
        end else begin
          timer_d = timer_q + C_TMR_ONE;
        end
      end
      S_PH4: begin
        if (w_phase_end) begin
          timer_d    = C_TMR_ONE;
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          {a_d, b_d} = 2'b00;
          pos_d      = w_pos_step;
          done_d     = (w_pos_step == target);
        end else begin
          timer_d = timer_q + C_TMR_ONE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        {a_d, b_d} = 2'b00;
      end
    endcase
  end

  assign A        = a_q;
  assign B        = b_q;
  assign position = pos_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire
